// File: rtl/spi_window_pkg.sv
// Shared types and defaults for the SPI column-to-window streamer.
// The state enum, default geometry and the message width helper live here.
package spi_window_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } win_state_e;

  localparam int DEF_PIXEL_BITS = 4;
  localparam int DEF_WINDOW     = 3;
  localparam int DEF_IMG_W      = 640;
  localparam int DEF_IMG_H      = 480;

  function automatic int msg_bits(input int pixel_bits, input int window);
    return pixel_bits * window;
  endfunction

endpackage

// File: rtl/spi_column_rx.sv
// spiClk-domain receiver: shifts one column word MSB first, then copies it to
// a holding register and toggles a flag for the mainClk side to pick up.
module spi_column_rx #(
  parameter int MSG_BITS = 12
) (
  input  logic                spiClk,
  input  logic                nreset,
  input  logic                ncs,
  input  logic                sdi,
  output logic [MSG_BITS-1:0] rx_word,
  output logic                rx_toggle
);

  localparam int CW = $clog2(MSG_BITS);

  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [MSG_BITS-1:0] shift_q, shift_d;
  logic [MSG_BITS-1:0] hold_q, hold_d;
  logic                toggle_q, toggle_d;
  logic                cnt_rst_n;

  // Deasserted chip select clears the bit count even with spiClk parked,
  // so a partial word can never merge with the next one.
  assign cnt_rst_n = nreset & ~ncs;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    toggle_d  = toggle_q;
    if (!ncs) begin
      shift_d = {shift_q[MSG_BITS-2:0], sdi};
      if (bit_cnt_q == CW'(MSG_BITS - 1)) begin
        bit_cnt_d = '0;
        hold_d    = shift_d;
        toggle_d  = ~toggle_q;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge spiClk or negedge cnt_rst_n) begin
    if (!cnt_rst_n) bit_cnt_q <= '0;
    else            bit_cnt_q <= bit_cnt_d;
  end

  always_ff @(posedge spiClk or negedge nreset) begin
    if (!nreset) begin
      shift_q  <= '0;
      hold_q   <= '0;
      toggle_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      hold_q   <= hold_d;
      toggle_q <= toggle_d;
    end
  end

  assign rx_word   = hold_q;
  assign rx_toggle = toggle_q;

endmodule

// File: rtl/spi_window_streamer.sv
// Assembles SPI-delivered pixel columns into KxK windows for a downstream
// consumer, tracking image position and flagging lost windows.
module spi_window_streamer
  import spi_window_pkg::*;
#(
  parameter int PIXEL_BITS = DEF_PIXEL_BITS,
  parameter int WINDOW     = DEF_WINDOW,
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H
) (
  input  logic                                 mainClk,
  input  logic                                 nreset,
  input  logic                                 spiClk,
  input  logic                                 ncs,
  input  logic                                 sdi,
  output logic [WINDOW*WINDOW*PIXEL_BITS-1:0]  windowData,
  output logic                                 windowValid,
  input  logic                                 windowReady,
  output logic [$clog2(IMG_W)-1:0]             winX,
  output logic [$clog2(IMG_H)-1:0]             winY,
  output logic                                 frameDone,
  output logic                                 overflow,
  input  logic                                 overflowClr,
  output logic                                 dbg_state
);

  localparam int MSG_BITS = msg_bits(PIXEL_BITS, WINDOW);
  localparam int XW       = $clog2(IMG_W);
  localparam int YW       = $clog2(IMG_H);
  localparam int PW       = $clog2(WINDOW);
  localparam int FW       = $clog2(WINDOW + 1);
  localparam int DW       = WINDOW * WINDOW * PIXEL_BITS;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [MSG_BITS-1:0] rx_word;
  logic                rx_toggle;

  spi_column_rx #(.MSG_BITS(MSG_BITS)) u_rx (
    .spiClk    (spiClk),
    .nreset    (nreset),
    .ncs       (ncs),
    .sdi       (sdi),
    .rx_word   (rx_word),
    .rx_toggle (rx_toggle)
  );

  logic [2:0]          tog_sync_q, tog_sync_d;
  logic                col_strobe;
  logic [MSG_BITS-1:0] ring_q [WINDOW];
  logic [MSG_BITS-1:0] ring_d [WINDOW];
  logic [MSG_BITS-1:0] cols   [WINDOW];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]       fill_q, fill_d, fill_next;
  logic [XW-1:0]       col_x_q, col_x_d;
  logic [YW-1:0]       col_y_q, col_y_d;
  logic [DW-1:0]       win_pack;
  logic [DW-1:0]       win_data_q, win_data_d;
  logic [XW-1:0]       win_x_q, win_x_d;
  logic [YW-1:0]       win_y_q, win_y_d;
  logic                frame_done_q, frame_done_d;
  logic                overflow_q, overflow_d;
  logic                new_win, ovf_set;
  win_state_e          state_q, state_d;

  // Bits [1:0] are the two synchroniser stages, bit 2 the edge-detect history.
  assign tog_sync_d = {tog_sync_q[1:0], rx_toggle};
  assign col_strobe = tog_sync_q[2] ^ tog_sync_q[1];

  always_comb begin
    int            tmp;
    logic [PW-1:0] idx;
    tmp       = 0;
    idx       = '0;
    cols      = '{default: '0};
    win_pack  = '0;
    for (int c = 0; c < WINDOW; c++) begin
      tmp = int'(wr_ptr_q) + 1 + c;
      if (tmp >= WINDOW) tmp = tmp - WINDOW;
      idx = PW'(tmp);
      cols[c] = (idx == wr_ptr_q) ? rx_word : ring_q[idx];
    end
    for (int r = 0; r < WINDOW; r++) begin
      for (int c = 0; c < WINDOW; c++) begin
        win_pack[(r*WINDOW+c)*PIXEL_BITS +: PIXEL_BITS] =
          cols[c][MSG_BITS-1-r*PIXEL_BITS -: PIXEL_BITS];
      end
    end
  end

  assign fill_next = (fill_q == FW'(WINDOW)) ? fill_q : fill_q + 1'b1;

  always_comb begin
    ring_d       = ring_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    col_x_d      = col_x_q;
    col_y_d      = col_y_q;
    win_data_d   = win_data_q;
    win_x_d      = win_x_q;
    win_y_d      = win_y_q;
    frame_done_d = 1'b0;
    new_win      = 1'b0;
    if (col_strobe) begin
      ring_d[wr_ptr_q] = rx_word;
      new_win          = (fill_next == FW'(WINDOW));
      if (new_win) begin
        win_data_d = win_pack;
        win_x_d    = col_x_q;
        win_y_d    = col_y_q;
      end
      // Line end restarts the fill so no window straddles two lines.
      if (col_x_q == X_LAST) begin
        col_x_d  = '0;
        wr_ptr_d = '0;
        fill_d   = '0;
        if (col_y_q == Y_LAST) begin
          col_y_d      = '0;
          frame_done_d = 1'b1;
        end else begin
          col_y_d = col_y_q + 1'b1;
        end
      end else begin
        col_x_d  = col_x_q + 1'b1;
        wr_ptr_d = (wr_ptr_q == PW'(WINDOW - 1)) ? '0 : wr_ptr_q + 1'b1;
        fill_d   = fill_next;
      end
    end
  end

  // Handshake: a window transfers on any mainClk edge with windowValid and
  // windowReady both high; while valid and not ready, data/winX/winY hold
  // unless a newer window replaces them (which raises overflow).
  always_comb begin
    state_d = state_q;
    ovf_set = 1'b0;
    case (state_q)
      IDLE: if (new_win) state_d = PEND;
      PEND: begin
        if (new_win) begin
          if (!windowReady) ovf_set = 1'b1;
        end else if (windowReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    overflow_d = ovf_set ? 1'b1 : (overflowClr ? 1'b0 : overflow_q);
  end

  always_ff @(posedge mainClk or negedge nreset) begin
    if (!nreset) begin
      tog_sync_q   <= '0;
      ring_q       <= '{default: '0};
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      col_x_q      <= '0;
      col_y_q      <= '0;
      win_data_q   <= '0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      state_q      <= IDLE;
    end else begin
      tog_sync_q   <= tog_sync_d;
      ring_q       <= ring_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      col_x_q      <= col_x_d;
      col_y_q      <= col_y_d;
      win_data_q   <= win_data_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      state_q      <= state_d;
    end
  end

  assign windowData  = win_data_q;
  assign windowValid = (state_q == PEND);
  assign winX        = win_x_q;
  assign winY        = win_y_q;
  assign frameDone   = frame_done_q;
  assign overflow    = overflow_q;
  assign dbg_state   = logic'(state_q);

endmodule
